// File: rtl/serial_adder_pkg.sv
// rtl/serial_adder_pkg.sv - shared types for the serial word adder
// Contents: BYTE_W, sa_state_t (IDLE/ADD/DONE), byte_t.
package serial_adder_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        ADD,
        DONE
    } sa_state_t;

    typedef logic [BYTE_W-1:0] byte_t;

endpackage

// File: rtl/adder.sv
// rtl/adder.sv - combinational 8-bit adder with carry in/out
// Ports: x, y (8b operands), carry_in, sum (8b), carry_output_bit.
module adder
    import serial_adder_pkg::*;
(
    input  byte_t x,
    input  byte_t y,
    input  logic  carry_in,
    output logic  carry_output_bit,
    output byte_t sum
);

    assign {carry_output_bit, sum} = {1'b0, x} + {1'b0, y} + {{BYTE_W{1'b0}}, carry_in};

endmodule

// File: rtl/serial_word_adder.sv
// rtl/serial_word_adder.sv - byte-serial wide adder sequencing the 8-bit adder
// Ports: clk, rst_n (sync, active-low); in_valid/in_ready/in_a/in_b/in_carry operand
// handshake; out_valid/out_ready/out_sum/out_carry result handshake.
module serial_word_adder
    import serial_adder_pkg::*;
#(
    parameter int WORD_BYTES = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [8*WORD_BYTES-1:0] in_a,
    input  logic [8*WORD_BYTES-1:0] in_b,
    input  logic                    in_carry,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [8*WORD_BYTES-1:0] out_sum,
    output logic                    out_carry
);

    localparam int IDX_W = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_BYTES - 1);

    sa_state_t                   state;
    logic [IDX_W-1:0]            idx;
    logic                        carry_q;
    byte_t [WORD_BYTES-1:0]      a_q;
    byte_t [WORD_BYTES-1:0]      b_q;
    byte_t [WORD_BYTES-1:0]      res_q;

    byte_t x_byte;
    byte_t y_byte;
    byte_t sum_byte;
    logic  carry_next;

    always_comb begin
        x_byte = a_q[idx];
        y_byte = b_q[idx];
    end

    adder u_adder (
        .x                (x_byte),
        .y                (y_byte),
        .carry_in         (carry_q),
        .carry_output_bit (carry_next),
        .sum              (sum_byte)
    );

    // The running carry doubles as the final carry once DONE is reached.
    assign out_sum   = res_q;
    assign out_carry = carry_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= '0;
            carry_q   <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            res_q     <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q      <= in_a;
                        b_q      <= in_b;
                        carry_q  <= in_carry;
                        idx      <= '0;
                        res_q    <= '0;
                        in_ready <= 1'b0;
                        state    <= ADD;
                    end
                end
                ADD: begin
                    res_q[idx] <= sum_byte;
                    carry_q    <= carry_next;
                    if (idx == LAST_IDX) begin
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule
